// File: rtl/plab4_net_router_tdm_out_sched_if.sv
// Output-port bundle between the input controls and the TDM output scheduler.
// Handshake: out_val says a message is presented this cycle; a transfer happens
// exactly when out_val & out_rdy, and only then is grants non-zero (zero-cycle latency).
interface plab4_net_router_tdm_out_sched_if;
    logic [2:0] reqs;
    logic [2:0] reqs_dom;
    logic       out_rdy;
    logic       out_val;
    logic [2:0] grants;
    logic [1:0] xbar_sel;

    modport master (
        output reqs, reqs_dom, out_rdy,
        input  out_val, grants, xbar_sel
    );

    modport slave (
        input  reqs, reqs_dom, out_rdy,
        output out_val, grants, xbar_sel
    );
endinterface

// File: rtl/plab4_net_router_tdm_out_sched.sv
// Two-domain TDM output-port scheduler with per-domain round-robin among {in0, ter, in1}.
// Optional grant counters are enabled by defining PLAB4_NET_TDM_STATS_EN.
module plab4_net_router_tdm_out_sched #(
    parameter int p_epoch_len   = 8,
    parameter int p_dead_cycles = 1,
    parameter int p_cnt_nbits   = 4
) (
    input  logic clk,
    input  logic reset,
    plab4_net_router_tdm_out_sched_if.slave sched_if,
    output logic cur_dom,
`ifdef PLAB4_NET_TDM_STATS_EN
    output logic [15:0] grant_cnt_d0,
    output logic [15:0] grant_cnt_d1,
`endif
    output logic epoch_start
);

    if (p_epoch_len < 1 || p_dead_cycles < 0 || p_dead_cycles >= p_epoch_len ||
        (64'(1) << p_cnt_nbits) < 64'(p_epoch_len)) begin : g_bad_params
        $fatal(1, "plab4_net_router_tdm_out_sched: illegal parameter combination");
    end

    localparam logic [p_cnt_nbits-1:0] cnt_last = p_cnt_nbits'(p_epoch_len - 1);
    // One bit wider so an all-active epoch of length 2^p_cnt_nbits does not wrap to zero.
    localparam logic [p_cnt_nbits:0]   act_end  = (p_cnt_nbits + 1)'(p_epoch_len - p_dead_cycles);

    logic [p_cnt_nbits-1:0] cnt_q, cnt_d;
    logic                   dom_q, dom_d;
    logic [2:0]             prio_d0_q, prio_d0_d;
    logic [2:0]             prio_d1_q, prio_d1_d;

    logic       active;
    logic [2:0] elig;
    logic [2:0] prio_cur;
    logic [2:0] prio_next;
    logic [1:0] win;
    logic       val;
    logic       xfer;

    always_comb begin
        cnt_d = cnt_q + p_cnt_nbits'(1);
        dom_d = dom_q;
        if (cnt_q == cnt_last) begin
            cnt_d = '0;
            dom_d = ~dom_q;
        end

        active   = ({1'b0, cnt_q} < act_end);
        elig     = sched_if.reqs & ~(sched_if.reqs_dom ^ {3{dom_q}});
        prio_cur = dom_q ? prio_d1_q : prio_d0_q;

        // Scan starts at the pointer position and wraps 2 -> 0.
        case (prio_cur)
            3'b010:  win = elig[1] ? 2'd1 : (elig[2] ? 2'd2 : 2'd0);
            3'b100:  win = elig[2] ? 2'd2 : (elig[0] ? 2'd0 : 2'd1);
            default: win = elig[0] ? 2'd0 : (elig[1] ? 2'd1 : 2'd2);
        endcase

        // Outputs are forced idle while reset is held, not just after the next edge.
        val  = reset & active & (|elig);
        xfer = val & sched_if.out_rdy;

        sched_if.out_val  = val;
        sched_if.grants   = xfer ? (3'b001 << win) : 3'b000;
        sched_if.xbar_sel = val ? win : 2'd0;

        prio_next = {win == 2'd1, win == 2'd0, win == 2'd2};
        prio_d0_d = prio_d0_q;
        prio_d1_d = prio_d1_q;
        if (xfer && !dom_q) prio_d0_d = prio_next;
        if (xfer &&  dom_q) prio_d1_d = prio_next;

        cur_dom     = dom_q;
        epoch_start = reset & (cnt_q == '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            dom_q     <= 1'b0;
            prio_d0_q <= 3'b001;
            prio_d1_q <= 3'b001;
        end else begin
            cnt_q     <= cnt_d;
            dom_q     <= dom_d;
            prio_d0_q <= prio_d0_d;
            prio_d1_q <= prio_d1_d;
        end
    end

`ifdef PLAB4_NET_TDM_STATS_EN
    logic [15:0] gcnt_d0_q, gcnt_d0_d;
    logic [15:0] gcnt_d1_q, gcnt_d1_d;

    always_comb begin
        gcnt_d0_d = gcnt_d0_q;
        gcnt_d1_d = gcnt_d1_q;
        if (xfer && !dom_q && gcnt_d0_q != 16'hFFFF) gcnt_d0_d = gcnt_d0_q + 16'd1;
        if (xfer &&  dom_q && gcnt_d1_q != 16'hFFFF) gcnt_d1_d = gcnt_d1_q + 16'd1;
        grant_cnt_d0 = gcnt_d0_q;
        grant_cnt_d1 = gcnt_d1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gcnt_d0_q <= '0;
            gcnt_d1_q <= '0;
        end else begin
            gcnt_d0_q <= gcnt_d0_d;
            gcnt_d1_q <= gcnt_d1_d;
        end
    end
`endif

endmodule
